// File: rtl/ms_seq_pkg.sv
// Shared phase encoding and widths for the master/slave register sequencer.
package ms_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_XFER   = 2'd3
    } phase_e;

    localparam int unsigned XFER_CNT_W = 8;

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-FF synchronizer, stability counter and a one-cycle pulse
// on each debounced rising level.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept the new level only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync_q        <= {sync_q[0], raw_i};
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/ms_reg_sequencer.sv
// Phase FSM sequencing a master/slave register pair from a debounced step switch
// or an auto-tick. Define MS_SEQ_XFER_COUNT_EN to enable the completed-transfer counter.
module ms_reg_sequencer
    import ms_seq_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned TICK_DIV     = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_i,
    input  logic                  auto_i,
    input  logic [WIDTH-1:0]      d_i,
    output logic [WIDTH-1:0]      master_q,
    output logic [WIDTH-1:0]      slave_q,
    output logic                  master_en_o,
    output logic                  slave_en_o,
    output logic [1:0]            state_o,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    logic              step_level;
    logic              step_pulse;
    logic [1:0]        auto_sync_q;
    logic              auto_s;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              adv;
    phase_e            state_q, state_d;

    sw_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_step_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (step_i),
        .level_o (step_level),
        .rise_o  (step_pulse)
    );

    assign auto_s = auto_sync_q[1];
    assign tick   = auto_s && (tick_cnt_q == TICK_MAX);

    // Held at zero while auto is off so the first tick lands a full period later.
    always_comb begin
        tick_cnt_d = '0;
        if (auto_s && !tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    assign adv = auto_s ? tick : step_pulse;

    always_comb begin
        state_d     = state_q;
        master_en_o = 1'b0;
        slave_en_o  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (adv) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                master_en_o = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD:   if (adv) state_d = ST_XFER;
            ST_XFER:   begin
                slave_en_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_sync_q <= '0;
            tick_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            master_q    <= '0;
            slave_q     <= '0;
        end else begin
            auto_sync_q <= {auto_sync_q[0], auto_i};
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            if (state_q == ST_SAMPLE) master_q <= d_i;
            if (state_q == ST_XFER)   slave_q  <= master_q;
        end
    end

    assign state_o = state_q;

`ifdef MS_SEQ_XFER_COUNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (state_q == ST_XFER) begin
            xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`else
    assign xfer_cnt_o = '0;
`endif

    // Debounced level is only observed through its rising-edge pulse here.
    logic unused_step_level;
    assign unused_step_level = step_level;

endmodule

// File: tb/tb_ms_reg_sequencer.sv
// Scoreboard bench for ms_reg_sequencer (DEBOUNCE_CYC=4, TICK_DIV=8, WIDTH=4).
module tb_ms_reg_sequencer;

    logic       clk;
    logic       rst_n;
    logic       step_i;
    logic       auto_i;
    logic [3:0] d_i;
    logic [3:0] master_q;
    logic [3:0] slave_q;
    logic       master_en_o;
    logic       slave_en_o;
    logic [1:0] state_o;
    logic [7:0] xfer_cnt_o;

    ms_reg_sequencer #(
        .WIDTH        (4),
        .DEBOUNCE_CYC (4),
        .TICK_DIV     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_i      (step_i),
        .auto_i      (auto_i),
        .d_i         (d_i),
        .master_q    (master_q),
        .slave_q     (slave_q),
        .master_en_o (master_en_o),
        .slave_en_o  (slave_en_o),
        .state_o     (state_o),
        .xfer_cnt_o  (xfer_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_xfer;
        logic [3:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_events = 0;

    // Reference model of the phase machine, advanced when a press/tick is scheduled
    int         m_state  = 0;
    logic [3:0] m_master = '0;
    int         m_xfers  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_adv();
        ev_t e;
        if (m_state == 0) begin
            e.is_xfer = 1'b0;
            e.val     = d_i;
            m_master  = d_i;
            m_state   = 2;
        end else begin
            e.is_xfer = 1'b1;
            e.val     = m_master;
            m_xfers++;
            m_state   = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_master = '0;
        m_xfers  = 0;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef MS_SEQ_XFER_COUNT_EN
        return 32'(m_xfers % 256);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_auto_state(input int k);
        if (k < 10)  return 32'd0;
        if (k == 10) return 32'd1;
        if (k < 18)  return 32'd2;
        if (k == 18) return 32'd3;
        return 32'd0;
    endfunction

    task automatic press();
        step_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 step_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Monitor: pop an expected event on each enable pulse, check the register a cycle later
    initial begin
        ev_t        e;
        logic       pend_m = 1'b0;
        logic       pend_s = 1'b0;
        logic [3:0] pend_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_m = 1'b0;
                pend_s = 1'b0;
            end else begin
                if (pend_m) chk("master_q_after_sample", 32'(master_q), 32'(pend_val));
                if (pend_s) chk("slave_q_after_xfer", 32'(slave_q), 32'(pend_val));
                pend_m = 1'b0;
                pend_s = 1'b0;
                if (master_en_o || slave_en_o) begin
                    n_events++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {30'd0, slave_en_o, master_en_o}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", 32'(slave_en_o), 32'(e.is_xfer));
                        chk("en_exclusive", 32'(master_en_o & slave_en_o), 32'd0);
                        pend_m   = master_en_o;
                        pend_s   = slave_en_o;
                        pend_val = e.val;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  waited;
        logic done;

        rst_n  = 1'b0;
        step_i = 1'b0;
        auto_i = 1'b0;
        d_i    = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_outputs", {16'd0, master_q, slave_q, 6'd0, master_en_o, slave_en_o}, 32'd0);
        chk("reset_cnt", 32'(xfer_cnt_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Async reset from HOLD with master_q = A
        d_i = 4'hA;
        model_adv();
        press();
        chk("pre_reset_state", 32'(state_o), 32'd2);
        chk("pre_reset_master", 32'(master_q), 32'hA);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(state_o), 32'd0);
        chk("async_reset_master", 32'(master_q), 32'd0);
        chk("async_reset_misc", {24'd0, slave_q, 2'd0, master_en_o, slave_en_o}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Manual cycle with exact press-to-SAMPLE latency
        d_i = 4'h5;
        model_adv();
        @(posedge clk);
        #1 step_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("lat_state_edge6", 32'(state_o), 32'd0);
        chk("lat_men_edge6", 32'(master_en_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_men_edge7", 32'(master_en_o), 32'd1);
        chk("lat_state_edge7", 32'(state_o), 32'd1);
        repeat (3) @(posedge clk);
        #1 step_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("manual_hold", 32'(state_o), 32'd2);
        chk("manual_master", 32'(master_q), 32'h5);
        model_adv();
        press();
        chk("manual_idle", 32'(state_o), 32'd0);
        chk("manual_slave", 32'(slave_q), 32'h5);
        chk("manual_cnt", 32'(xfer_cnt_o), exp_cnt());

        // Bouncy press yields exactly one advance
        d_i = 4'hC;
        model_adv();
        for (int i = 0; i < 10; i++) begin
            step_i = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        step_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bounce_hold", 32'(state_o), 32'd2);
        step_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bounce_still_hold", 32'(state_o), 32'd2);
        model_adv();
        press();
        chk("bounce_slave", 32'(slave_q), 32'hC);

        // Auto loop; step press held meanwhile must be ignored
        d_i = 4'h3;
        model_adv();
        model_adv();
        @(posedge clk);
        #1;
        auto_i = 1'b1;
        step_i = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (k == 19) auto_i = 1'b0;
            @(negedge clk);
            chk($sformatf("auto_state_k%0d", k), 32'(state_o), exp_auto_state(k));
        end
        step_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("auto_idle", 32'(state_o), 32'd0);
        chk("auto_slave", 32'(slave_q), 32'h3);

        // Switch to auto while in HOLD
        d_i = 4'h9;
        model_adv();
        press();
        chk("switch_hold", 32'(state_o), 32'd2);
        model_adv();
        auto_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 11) auto_i = 1'b0;
            @(negedge clk);
            chk($sformatf("switch_state_k%0d", k), 32'(state_o),
                (k < 10) ? 32'd2 : ((k == 10) ? 32'd3 : 32'd0));
        end
        repeat (10) @(posedge clk);
        #1;
        chk("switch_slave", 32'(slave_q), 32'h9);
        chk("switch_idle", 32'(state_o), 32'd0);

        // 257 auto transfers from reset
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        d_i = 4'h6;
        for (int i = 0; i < 257; i++) begin
            model_adv();
            model_adv();
        end
        base   = n_events;
        done   = 1'b0;
        waited = 0;
        auto_i = 1'b1;
        while (!done && waited < 5000) begin
            @(negedge clk);
            waited++;
            if (n_events - base >= 514) done = 1'b1;
        end
        auto_i = 1'b0;
        chk("auto_257_done", 32'(done), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("cnt_257", 32'(xfer_cnt_o), exp_cnt());
        chk("cnt_257_state", 32'(state_o), 32'd0);
        chk("cnt_257_slave", 32'(slave_q), 32'h6);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ms_reg_sequencer.md
Name: ms_reg_sequencer

Overview:
- Controller that sequences a WIDTH-bit master/slave register pair (master-slave D flip-flop datapath) from board switches on the 50 MHz clock.
- A step switch, or an internal auto-tick, advances a 4-state phase FSM.
  - First advance: captures d_i into the master stage.
  - Second advance: transfers the master stage into the slave stage.
- Outputs drive LEDR for phase and register observation in the lab top level.

Parameters:
- WIDTH, 4, data width of d_i / master_q / slave_q.
- DEBOUNCE_CYC, 500000, consecutive stable cycles required before step accepted (10 ms at 50 MHz); must be >= 2.
- TICK_DIV, 25000000, clock cycles per auto advance (0.5 s); must be >= 2.

Ports:
- clk, input, 1, system clock (MAX10_CLK1_50 at top).
- rst_n, input, 1, reset; asynchronous, active-low.
- step_i, input, 1, raw step switch, asynchronous, bouncy.
- auto_i, input, 1, 1 = auto-tick advances, 0 = step_i advances; asynchronous.
- d_i, input, WIDTH, data to capture; sampled only in SAMPLE.
- master_q, output, WIDTH, master stage contents.
- slave_q, output, WIDTH, slave stage contents.
- master_en_o, output, 1, one-cycle pulse in SAMPLE.
- slave_en_o, output, 1, one-cycle pulse in XFER.
- state_o, output, 2, current phase encoding.
- xfer_cnt_o, output, 8, completed-transfer count (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state IDLE, all counters/synchronizers 0, debounced level 0.
- Synchronization:
  - step_i and auto_i each pass through a 2-FF synchronizer.
  - d_i is quasi-static and is not synchronized.
- Debounce:
  - Counter increments each cycle while sync step != stable level; clears whenever equal.
  - On the edge where the counter == DEBOUNCE_CYC-1 and inputs still differ: stable <= sync step, counter <= 0.
  - step_pulse = stable & ~stable_d (one cycle per press); release produces no pulse.
- Auto tick:
  - Counter runs 0..TICK_DIV-1 while sync auto == 1.
  - tick is high when count == TICK_DIV-1; counter then wraps to 0.
  - Counter is held at 0 while sync auto == 0, so the first tick after enabling comes TICK_DIV cycles later.
- Advance source: adv = sync auto ? tick : step_pulse. Step pulses are ignored while auto is active.
- FSM (state_o encoding):
  - IDLE = 0: on adv -> SAMPLE.
  - SAMPLE = 1: master_en_o = 1; master_q <= d_i at the exiting edge; unconditionally -> HOLD.
  - HOLD = 2: on adv -> XFER.
  - XFER = 3: slave_en_o = 1; slave_q <= master_q at the exiting edge; unconditionally -> IDLE.
- adv arriving while in SAMPLE or XFER is dropped, not queued.
- master_en_o / slave_en_o are decoded from the registered state: high exactly 1 cycle per visit.
- Latency:
  - step_i rising before edge 1 and held: stable rises at edge 2+DEBOUNCE_CYC; step_pulse is high in the following cycle; SAMPLE is entered at edge 3+DEBOUNCE_CYC.
  - master_q updates at edge 4+DEBOUNCE_CYC.
- Mode change mid-operation: FSM state is kept (e.g. HOLD survives a switch to auto); only the advance source changes.
- Reset mid-operation: immediate return to reset values; no partial transfer.

Optional Feature:
- Macro: MS_SEQ_XFER_COUNT_EN.
- Defined: xfer_cnt_o increments by 1 on each exit from XFER; wraps 255 -> 0; reset to 0.
- Undefined: counter logic is absent; xfer_cnt_o is tied to 8'd0.

Decomposition:
- Package ms_seq_pkg:
  - phase enum with constants ST_IDLE=2'd0, ST_SAMPLE=2'd1, ST_HOLD=2'd2, ST_XFER=2'd3.
  - XFER_CNT_W=8.
- One sub-module, sw_debounce (params DEBOUNCE_CYC; ports clk, rst_n, raw_i, level_o, rise_o), containing the synchronizer and debounce counter.
- The auto-tick divider and FSM stay in ms_reg_sequencer.

Test Plan (DEBOUNCE_CYC=4, TICK_DIV=8, WIDTH=4):
- Reset: assert rst_n=0 mid-HOLD with master_q=4'hA -> all outputs 0 and state_o=0 with no clock edge.
- Manual cycle: d_i=4'h5, clean step_i pulses twice -> master_en_o high in cycle after edge 7, master_q=5; next press -> slave_en_o pulse, slave_q=5, state returns 0.
- Bounce: step_i toggles every cycle for 10 cycles then settles high -> exactly one step_pulse, state_o 0->1->2.
- Auto mode: auto_i=1, d_i=4'h3 -> advances every 8 cycles; full IDLE->SAMPLE->HOLD->XFER->IDLE loop with slave_q=3; step presses during auto produce no transition.
- Mode switch in HOLD: go to HOLD manually, set auto_i=1 -> XFER occurs 8 cycles after the synchronized auto rises; state stays HOLD before that.
- MS_SEQ_XFER_COUNT_EN defined: 257 auto transfers -> xfer_cnt_o=1. Undefined: xfer_cnt_o stays 0.
